madd_divrem_seq: RTL and testbench

//   Inverse of the 2x2 multiply-add (P = A*B + C). Sequential restoring divider:

---
 rtl/madd_pkg.sv | 20 ++
 rtl/madd_div_step.sv | 28 ++
 rtl/madd_divrem_seq.sv | 115 +++++++++++
 tb/tb_madd_divrem_seq.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/madd_pkg.sv
// Shared types and defaults for the madd divide/remainder checker.
// Holds the FSM state enum, default widths and counter-width helper.
package madd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int DW_DEF = 4;
    localparam int BW_DEF = 2;
    localparam int CNT_W  = $clog2(DW_DEF);

    // Counter width for a given dividend width; never below one bit.
    function automatic int cnt_w(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/madd_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract if possible.
// Ports: rem/bit_in/divisor in; rem_next (new partial remainder), q_bit out.
module madd_div_step #(
    parameter int BW = 2
) (
    input  logic [BW-1:0] rem,
    input  logic          bit_in,
    input  logic [BW-1:0] divisor,
    output logic [BW-1:0] rem_next,
    output logic          q_bit
);

    logic [BW:0] trial;
    logic [BW:0] dvs_ext;

    assign trial   = {rem, bit_in};
    assign dvs_ext = {1'b0, divisor};
    assign q_bit   = (trial >= dvs_ext);

    // rem < divisor on entry, so trial - divisor < divisor and fits BW bits.
    always_comb begin
        rem_next = trial[BW-1:0];
        if (q_bit) begin
            rem_next = BW'(trial - dvs_ext);
        end
    end

endmodule

// File: rtl/madd_divrem_seq.sv
// Sequential restoring divider recovering Q, R from P = Q*B + R.
// Ports: clk, rst; in_valid/in_ready/in_dividend/in_divisor;
// out_valid/out_ready/out_quotient/out_remainder/out_div_zero.
module madd_divrem_seq
    import madd_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int BW = BW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_dividend,
    input  logic [BW-1:0] in_divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_quotient,
    output logic [BW-1:0] out_remainder,
    output logic          out_div_zero
);

    localparam int CW = cnt_w(DW);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] q_q;
    logic [BW-1:0] rem_q;
    logic [BW-1:0] dvs_q;
    logic          dz_q;
    logic [BW-1:0] rem_nx;
    logic          q_bit;
    logic          accept;
    logic          last;

    madd_div_step #(.BW(BW)) u_step (
        .rem      (rem_q),
        .bit_in   (q_q[DW-1]),
        .divisor  (dvs_q),
        .rem_next (rem_nx),
        .q_bit    (q_bit)
    );

    assign accept = in_valid && (state_q == IDLE);
    assign last   = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (in_divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Q register doubles as the dividend shift register: its MSB feeds
    // the step while the new quotient bit enters at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            q_q   <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            dz_q  <= 1'b0;
        end else if (accept) begin
            cnt_q <= CW'(DW - 1);
            dvs_q <= in_divisor;
            rem_q <= '0;
            if (in_divisor == '0) begin
                q_q  <= '1;
                dz_q <= 1'b1;
            end else begin
                q_q  <= in_dividend;
                dz_q <= 1'b0;
            end
        end else if (state_q == CALC) begin
            q_q   <= (q_q << 1) | DW'(q_bit);
            rem_q <= rem_nx;
            if (!last) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign out_quotient  = q_q;
    assign out_remainder = rem_q;
    assign out_div_zero  = dz_q;

endmodule

// File: tb/tb_madd_divrem_seq.sv
// Directed self-checking bench for madd_divrem_seq (DW=4, BW=2).
// Covers reset, latency, divide-by-zero, madd round-trip, stall, abort, churn.
module tb_madd_divrem_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_dividend;
    logic [1:0] in_divisor;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_quotient;
    logic [1:0] out_remainder;
    logic       out_div_zero;

    int n_cmp = 0;
    int n_bad = 0;

    madd_divrem_seq #(.DW(4), .BW(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_div_zero  (out_div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one job, wait for the result, check it, hold it for
    // `hold` stalled cycles, then complete the handshake.
    task automatic job(input string tag, input logic [3:0] p,
                       input logic [1:0] b, input logic [3:0] eq,
                       input logic [1:0] er, input logic edz,
                       input int elat, input bit churn, input int hold);
        int lat;
        in_valid    = 1'b1;
        in_dividend = p;
        in_divisor  = b;
        chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (churn) begin
                in_dividend = 4'($urandom);
                in_divisor  = 2'($urandom);
            end
            tick();
            lat++;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(elat));
        chk({tag, ".q"}, 32'(out_quotient), 32'(eq));
        chk({tag, ".r"}, 32'(out_remainder), 32'(er));
        chk({tag, ".dz"}, 32'(out_div_zero), 32'(edz));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, ".hv"}, 32'(out_valid), 32'd1);
            chk({tag, ".hrdy"}, 32'(in_ready), 32'd0);
            chk({tag, ".hq"}, 32'(out_quotient), 32'(eq));
            chk({tag, ".hr"}, 32'(out_remainder), 32'(er));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".drop"}, 32'(out_valid), 32'd0);
        chk({tag, ".idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        out_ready   = 1'b0;
        tick();
        tick();
        chk("rst.rdy", 32'(in_ready), 32'd1);
        chk("rst.v", 32'(out_valid), 32'd0);
        chk("rst.q", 32'(out_quotient), 32'd0);
        chk("rst.r", 32'(out_remainder), 32'd0);
        chk("rst.dz", 32'(out_div_zero), 32'd0);
        rst = 1'b0;
        tick();

        job("p13b3", 4'd13, 2'd3, 4'd4, 2'd1, 1'b0, 4, 1'b0, 0);
        job("p9b0", 4'd9, 2'd0, 4'd15, 2'd0, 1'b1, 0, 1'b0, 0);

        for (int a = 0; a < 4; a++) begin
            for (int b = 1; b < 4; b++) begin
                for (int c = 0; c < b; c++) begin
                    job($sformatf("inv_a%0d_b%0d_c%0d", a, b, c),
                        4'(a * b + c), 2'(b), 4'(a), 2'(c),
                        1'b0, 4, 1'b0, 0);
                end
            end
        end

        job("bp", 4'd15, 2'd1, 4'd15, 2'd0, 1'b0, 4, 1'b0, 5);

        in_valid    = 1'b1;
        in_dividend = 4'd10;
        in_divisor  = 2'd2;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.rdy", 32'(in_ready), 32'd1);
        chk("abort.v", 32'(out_valid), 32'd0);
        chk("abort.q", 32'(out_quotient), 32'd0);
        chk("abort.r", 32'(out_remainder), 32'd0);
        chk("abort.dz", 32'(out_div_zero), 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("abort.nov", 32'(seen), 32'd0);
        job("p7b2", 4'd7, 2'd2, 4'd3, 2'd1, 1'b0, 4, 1'b0, 0);

        job("churn1", 4'd14, 2'd3, 4'd4, 2'd2, 1'b0, 4, 1'b1, 0);
        job("churn2", 4'd11, 2'd2, 4'd5, 2'd1, 1'b0, 4, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
